// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcodes, shift kinds, flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_BIC = 4'hD, OP_MVN = 4'hE, OP_MOV = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_t;

  // Bit positions inside the 4-bit NZCV vector
  localparam int NEG = 0;
  localparam int ZER = 1;
  localparam int CAR = 2;
  localparam int OVR = 3;

  // Test/compare ops only produce flags; their result is never written back
  function automatic logic is_test(opcode_t op);
    return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction

endpackage

// File: rtl/alu_pipe_barrel_shifter.sv
// Combinational operand-B shifter with shifter carry-out.
// A zero shift amount passes b unchanged and forwards cin as the carry.
module barrel_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] b,
  input  shift_t           sh_type,
  input  logic [SHW-1:0]   shamt,
  input  logic             cin,
  output logic [WIDTH-1:0] bs,
  output logic             sc
);

  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [SHW:0]     ror_back;
  logic [WIDTH-1:0] ror_val;

  // One extra bit on each extended vector catches the last bit shifted out
  always_comb begin
    // NOTE: every output is given a default before the case so no path leaves it unassigned (no latch).
    bs       = b;
    sc       = cin;
    lsl_ext  = {1'b0, b} << shamt;
    lsr_ext  = {b, 1'b0} >> shamt;
    asr_ext  = $signed({b, 1'b0}) >>> shamt;
    ror_back = (SHW+1)'(WIDTH) - {1'b0, shamt};
    ror_val  = (b >> shamt) | (b << ror_back);
    if (shamt != '0) begin
      unique case (sh_type)
        SH_LSL: begin bs = lsl_ext[WIDTH-1:0]; sc = lsl_ext[WIDTH]; end
        SH_LSR: begin bs = lsr_ext[WIDTH:1];   sc = lsr_ext[0];     end
        SH_ASR: begin bs = asr_ext[WIDTH:1];   sc = asr_ext[0];     end
        SH_ROR: begin bs = ror_val;            sc = ror_val[WIDTH-1]; end
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU: shifted operand B, 16 data-processing ops,
// one result register with valid/ready handshake and the committed NZCV register.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_shift_type,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_wr,
  output logic [3:0]       out_flags,
  output logic [3:0]       flags,
  input  logic             flags_load,
  input  logic [3:0]       flags_wdata
);

  opcode_t          op;
  logic [WIDTH-1:0] bs;
  logic             sc;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic [3:0]       op_flags;
  logic [3:0]       next_flags;
  logic             accept;

  assign op       = opcode_t'(in_opcode);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .b       (in_b),
    .sh_type (shift_t'(in_shift_type)),
    .shamt   (in_shamt),
    .cin     (flags[CAR]),
    .bs      (bs),
    .sc      (sc)
  );

  // Op mux and shared adder; subtract forms feed the adder an inverted operand
  always_comb begin
    add_x   = in_a;
    add_y   = bs;
    add_cin = 1'b0;
    arith   = 1'b1;
    res     = '0;
    unique case (op)
      OP_AND, OP_TST: begin arith = 1'b0; res = in_a & bs;  end
      OP_EOR, OP_TEQ: begin arith = 1'b0; res = in_a ^ bs;  end
      OP_ORR:         begin arith = 1'b0; res = in_a | bs;  end
      OP_BIC:         begin arith = 1'b0; res = in_a & ~bs; end
      OP_MOV:         begin arith = 1'b0; res = bs;         end
      OP_MVN:         begin arith = 1'b0; res = ~bs;        end
      OP_SUB, OP_CMP: begin add_y = ~bs;   add_cin = 1'b1; end
      OP_RSB:         begin add_x = bs; add_y = ~in_a; add_cin = 1'b1; end
      OP_ADD, OP_CMN: ;
      OP_ADC:         add_cin = flags[CAR];
      OP_SBC:         begin add_y = ~bs;   add_cin = flags[CAR]; end
      OP_RSC:         begin add_x = bs; add_y = ~in_a; add_cin = flags[CAR]; end
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    if (arith) res = sum[WIDTH-1:0];

    // Carry is adder carry-out (not borrow) for arithmetic, shifter carry otherwise
    op_flags[NEG] = res[WIDTH-1];
    op_flags[ZER] = (res == '0);
    op_flags[CAR] = arith ? sum[WIDTH] : sc;
    op_flags[OVR] = arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) && (res[WIDTH-1] != add_x[WIDTH-1]))
                          : flags[OVR];
    next_flags    = in_set_flags ? op_flags : flags;
  end

  // Output register: load on accept, drop valid once the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use <= so every flop samples pre-edge values; always_comb uses = instead.
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_wr     <= 1'b0;
      out_flags  <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= res;
      out_wr     <= !is_test(op);
      out_flags  <= next_flags;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Committed flags: a flag-setting accept beats an external load in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
    end else if (accept && in_set_flags) begin
      flags <= op_flags;
    end else if (flags_load) begin
      flags <= flags_wdata;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a reference model computes each op's result
// when it is accepted; the monitor pops and compares when the consumer takes it.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_opcode;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [1:0]     in_shift_type;
  logic [SHW-1:0] in_shamt;
  logic           in_set_flags;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic           out_wr;
  logic [3:0]     out_flags;
  logic [3:0]     flags;
  logic           flags_load;
  logic [3:0]     flags_wdata;

  alu_pipe #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_shift_type (in_shift_type),
    .in_shamt      (in_shamt),
    .in_set_flags  (in_set_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_wr        (out_wr),
    .out_flags     (out_flags),
    .flags         (flags),
    .flags_load    (flags_load),
    .flags_wdata   (flags_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        wr;
    logic [3:0]  fl;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] mflags;
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         rand_bp  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: 64-bit unsigned sum for carry, signed range test for overflow
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] st, input logic [4:0] sh, input logic s,
                                 input logic [3:0] f);
    logic [31:0]     bs, x32, y32, r;
    logic            sc, arith, cin, c, v;
    longint unsigned usum;
    longint          ssum;
    exp_t            e;
    bs = b;
    sc = f[2];
    if (sh != 0) begin
      case (st)
        2'd0:    begin bs = b << sh;                      sc = b[32 - int'(sh)]; end
        2'd1:    begin bs = b >> sh;                      sc = b[int'(sh) - 1];  end
        2'd2:    begin bs = $signed(b) >>> sh;            sc = b[int'(sh) - 1];  end
        default: begin bs = (b >> sh) | (b << (32 - int'(sh))); sc = b[int'(sh) - 1]; end
      endcase
    end
    arith = 1'b1; cin = 1'b0; x32 = a; y32 = bs; r = '0;
    case (op)
      4'h0, 4'h8: begin arith = 1'b0; r = a & bs;  end
      4'h1, 4'h9: begin arith = 1'b0; r = a ^ bs;  end
      4'hC:       begin arith = 1'b0; r = a | bs;  end
      4'hD:       begin arith = 1'b0; r = a & ~bs; end
      4'hE:       begin arith = 1'b0; r = ~bs;     end
      4'hF:       begin arith = 1'b0; r = bs;      end
      4'h2, 4'hA: begin y32 = ~bs; cin = 1'b1; end
      4'h3:       begin x32 = bs; y32 = ~a; cin = 1'b1; end
      4'h5:       cin = f[2];
      4'h6:       begin y32 = ~bs; cin = f[2]; end
      4'h7:       begin x32 = bs; y32 = ~a; cin = f[2]; end
      default:    ;
    endcase
    usum = {32'b0, x32} + {32'b0, y32} + {63'b0, cin};
    ssum = longint'($signed(x32)) + longint'($signed(y32)) + longint'({63'b0, cin});
    c = usum[32];
    v = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    if (arith) r = usum[31:0];
    e.res = r;
    e.wr  = !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
    e.fl  = s ? {arith ? v : f[3], arith ? c : sc, (r == 32'd0), r[31]} : f;
    return e;
  endfunction

  // Drive one op from the negedge and hold it until in_ready admits it
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] st, input logic [4:0] sh, input logic s);
    exp_t e;
    int   waited;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    in_shift_type = st; in_shamt = sh; in_set_flags = s;
    waited = 0;
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(op, a, b, st, sh, s, mflags);
    sb.push_back(e);
    if (s) mflags = e.fl;
    else if (flags_load) mflags = flags_wdata;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: a transfer happens on the next posedge when valid & ready here
  always begin
    @(negedge clk);
    #2;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", out_result, mon_e.res);
        check("out_wr", 32'(out_wr), 32'(mon_e.wr));
        check("out_flags", 32'(out_flags), 32'(mon_e.fl));
      end
    end
  end

  // Random consumer backpressure for the mixed-op phase
  always @(negedge clk) if (rand_bp) out_ready = 1'($urandom_range(0, 1));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0;
    in_shift_type = '0; in_shamt = '0; in_set_flags = 1'b0; out_ready = 1'b1;
    flags_load = 1'b0; flags_wdata = '0; mflags = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_flags", 32'(out_flags), 32'h0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Signed overflow on ADD
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 2'd0, 5'd0, 1'b1);
    check("add_ovf_result", out_result, 32'h8000_0000);
    check("add_ovf_flags", 32'(flags), 32'h9);

    // CMP then ADC back-to-back: ADC consumes CMP's carry
    send(OP_CMP, 32'd5, 32'd5, 2'd0, 5'd0, 1'b1);
    check("cmp_flags", 32'(flags), 32'h6);
    check("cmp_wr", 32'(out_wr), 32'd0);
    send(OP_ADC, 32'd1, 32'd1, 2'd0, 5'd0, 1'b1);
    check("adc_result", out_result, 32'd3);
    check("adc_flags", 32'(flags), 32'h0);

    // Shifter carry and sign fill
    send(OP_MOV, 32'd0, 32'h8000_0001, 2'd0, 5'd1, 1'b1);
    check("mov_lsl_result", out_result, 32'h0000_0002);
    check("mov_lsl_flags", 32'(flags), 32'h4);
    send(OP_MOV, 32'd0, 32'h8000_0000, 2'd2, 5'd4, 1'b0);
    check("mov_asr_result", out_result, 32'hF800_0000);

    // Backpressure: second op waits while the first result is held
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2, 2'd0, 5'd0, 1'b0);
    fork
      send(OP_SUB, 32'd9, 32'd4, 2'd0, 5'd0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          #3;
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_held_result", out_result, 32'd3);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join

    // Flag-setting accept beats a simultaneous flags_load
    send(OP_CMP, 32'd5, 32'd5, 2'd0, 5'd0, 1'b1);
    flags_load = 1'b1; flags_wdata = 4'hF;
    send(OP_EOR, 32'd0, 32'd0, 2'd0, 5'd0, 1'b1);
    flags_load = 1'b0;
    check("load_vs_op_flags", 32'(flags), 32'h6);

    // Plain external load, then a load alongside a non-flag-setting accept
    @(negedge clk);
    flags_load = 1'b1; flags_wdata = 4'hA;
    @(posedge clk);
    #1;
    flags_load = 1'b0;
    mflags = 4'hA;
    check("load_only_flags", 32'(flags), 32'hA);
    flags_load = 1'b1; flags_wdata = 4'h3;
    send(OP_AND, 32'hFF, 32'h0F, 2'd0, 5'd0, 1'b0);
    flags_load = 1'b0;
    check("load_nos_flags", 32'(flags), 32'h3);

    // Mixed random ops under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom,
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("model_flags", 32'(flags), 32'(mflags));

    // Reset while a result is held
    @(negedge clk);
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd1, 2'd0, 5'd0, 1'b1);
    @(negedge clk);
    #3;
    check("held_before_reset", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_flags", 32'(flags), 32'h0);
    check("midrst_result", out_result, 32'h0);
    sb.delete();
    mflags = '0;
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    send(OP_SUB, 32'd2, 32'd3, 2'd0, 5'd0, 1'b1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("final_empty", 32'(sb.size()), 32'd0);
    check("final_flags", 32'(flags), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
